// File: rtl/noc_injection_queue.sv
// Per-node injection FIFO between a core's flit output and the local port of its mesh router.
// Optional NOC_INJ_STATS_EN adds saturating injected-flit and stall counters.
module noc_injection_queue #(
  parameter int PL      = 32,
  parameter int DEPTH   = 4,
  parameter int NODE_ID = 0,
  parameter int NODES   = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [0:PL-1] core_flit,
  output logic          core_ready,
  input  logic          router_avail,
  output logic [0:PL-1] noc_flit,
  output logic          err_bad_dest,
  output logic [15:0]   stat_sent,
  output logic [15:0]   stat_stall
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  // A node id outside the mesh means a broken instantiation; reject every flit rather than inject garbage.
  localparam int unsigned DEST_LIMIT = (NODE_ID < NODES) ? NODES : 0;

  typedef enum logic [1:0] {
    Q_EMPTY,
    Q_PARTIAL,
    Q_FULL
  } q_state_e;

  logic [0:PL-1] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  q_state_e      q_state;

  logic [3:0] dest;
  logic       dest_legal;
  logic       offer;
  logic       push;
  logic       pop;

  always_comb begin
    q_state = Q_PARTIAL;
    if (count == '0)            q_state = Q_EMPTY;
    else if (count == FULL_CNT) q_state = Q_FULL;
  end

  // Ready depends on occupancy only: a full queue never takes a flit, even when the head pops this cycle.
  assign core_ready = (q_state != Q_FULL);

  assign dest       = core_flit[1:4];
  assign dest_legal = (32'(dest) < DEST_LIMIT);
  assign offer      = core_flit[0] && core_ready;
  assign push       = offer && dest_legal;
  assign pop        = (q_state != Q_EMPTY) && router_avail;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      noc_flit     <= '0;
      err_bad_dest <= 1'b0;
    end else begin
      err_bad_dest <= offer && !dest_legal;
      noc_flit     <= pop ? mem[rd_ptr] : '0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= core_flit;
  end

`ifdef NOC_INJ_STATS_EN
  logic stall;
  assign stall = (q_state != Q_EMPTY) && !router_avail;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_sent  <= '0;
      stat_stall <= '0;
    end else begin
      if (pop && stat_sent != 16'hFFFF)    stat_sent  <= stat_sent + 16'd1;
      if (stall && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
    end
  end
`else
  assign stat_sent  = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_noc_injection_queue.sv
// Directed bench for noc_injection_queue (PL=32, DEPTH=4, NODE_ID=0, NODES=9).
// Expected values are hand-derived; stats expectations follow NOC_INJ_STATS_EN.
module tb_noc_injection_queue;

  localparam int PL = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [0:PL-1] core_flit;
  logic          core_ready;
  logic          router_avail;
  logic [0:PL-1] noc_flit;
  logic          err_bad_dest;
  logic [15:0]   stat_sent;
  logic [15:0]   stat_stall;

  int pass_cnt = 0;
  int total    = 0;

  noc_injection_queue #(.PL(PL), .DEPTH(4), .NODE_ID(0), .NODES(9)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_flit    (core_flit),
    .core_ready   (core_ready),
    .router_avail (router_avail),
    .noc_flit     (noc_flit),
    .err_bad_dest (err_bad_dest),
    .stat_sent    (stat_sent),
    .stat_stall   (stat_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [0:PL-1] mk_flit(input logic [3:0] d, input logic [26:0] payload);
    logic [0:PL-1] f;
    f         = '0;
    f[0]      = 1'b1;
    f[1:4]    = d;
    f[5:PL-1] = payload;
    return f;
  endfunction

  // Outputs are observed 1 time unit after the rising edge; inputs change at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  logic [0:PL-1] f_a, f1, f2, f3, f4, f5, g, f_bad, f8, f0;
  logic [15:0]   exp_sent, exp_stall;

  initial begin
    f_a   = mk_flit(4'd3, 27'hABC);
    f1    = mk_flit(4'd1, 27'h111);
    f2    = mk_flit(4'd2, 27'h222);
    f3    = mk_flit(4'd3, 27'h333);
    f4    = mk_flit(4'd4, 27'h444);
    f5    = mk_flit(4'd5, 27'h555);
    g     = mk_flit(4'd6, 27'h666);
    f_bad = mk_flit(4'd9, 27'h999);
    f8    = mk_flit(4'd8, 27'h888);
    f0    = mk_flit(4'd0, 27'h000);

    rst          = 1'b1;
    core_flit    = '0;
    router_avail = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_noc_flit", noc_flit, 32'h0);
    check("rst_err", 32'(err_bad_dest), 32'h0);
    check("rst_ready", 32'(core_ready), 32'h1);
    check("rst_stat_sent", 32'(stat_sent), 32'h0);
    check("rst_stat_stall", 32'(stat_stall), 32'h0);

    // 1: single flit, empty queue, router available
    core_flit = f_a;
    step();
    core_flit = '0;
    check("t1_not_yet", noc_flit, 32'h0);
    step();
    check("t1_out", noc_flit, f_a);
    step();
    check("t1_one_cycle", noc_flit, 32'h0);

    // 2: fill with router blocked, drop a 5th, then drain in order
    router_avail = 1'b0;
    core_flit = f1; step();
    core_flit = f2; step();
    core_flit = f3; step();
    check("t2_ready_before_4th", 32'(core_ready), 32'h1);
    core_flit = f4; step();
    check("t2_full_not_ready", 32'(core_ready), 32'h0);
    core_flit = f5; step();
    core_flit = '0;
    check("t2_still_full", 32'(core_ready), 32'h0);
    check("t2_blocked_idle", noc_flit, 32'h0);
    router_avail = 1'b1;
    step();
    check("t2_out1", noc_flit, f1);
    check("t2_ready_after_pop", 32'(core_ready), 32'h1);
    step(); check("t2_out2", noc_flit, f2);
    step(); check("t2_out3", noc_flit, f3);
    step(); check("t2_out4", noc_flit, f4);
    step(); check("t2_no_5th", noc_flit, 32'h0);

    // 3: full queue with push+pop, then push+pop at count 3
    router_avail = 1'b0;
    core_flit = f1; step();
    core_flit = f2; step();
    core_flit = f3; step();
    core_flit = f4; step();
    check("t3_full", 32'(core_ready), 32'h0);
    core_flit = g;
    router_avail = 1'b1;
    step();
    check("t3_pop_at_full", noc_flit, f1);
    check("t3_count3_ready", 32'(core_ready), 32'h1);
    step();
    core_flit = '0;
    check("t3_pushpop_out", noc_flit, f2);
    check("t3_count_held3", 32'(core_ready), 32'h1);
    step(); check("t3_out3", noc_flit, f3);
    step(); check("t3_out4", noc_flit, f4);
    step(); check("t3_out_g", noc_flit, g);
    step(); check("t3_empty", noc_flit, 32'h0);

    // 4: illegal destination dropped; boundary dest=8 and loopback dest=NODE_ID kept
    core_flit = f_bad;
    step();
    core_flit = '0;
    check("t4_err_pulse", 32'(err_bad_dest), 32'h1);
    check("t4_no_out", noc_flit, 32'h0);
    step();
    check("t4_err_cleared", 32'(err_bad_dest), 32'h0);
    check("t4_nothing_stored", noc_flit, 32'h0);
    core_flit = f8;
    step();
    core_flit = f0;
    check("t4_dest8_no_err", 32'(err_bad_dest), 32'h0);
    step();
    core_flit = '0;
    check("t4_dest8_out", noc_flit, f8);
    check("t4_dest0_no_err", 32'(err_bad_dest), 32'h0);
    step();
    check("t4_dest0_out", noc_flit, f0);

    // 5: reset with 3 flits queued discards them
    router_avail = 1'b0;
    core_flit = f1; step();
    core_flit = f2; step();
    core_flit = f3; step();
    core_flit = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_noc_after_rst", noc_flit, 32'h0);
    check("t5_ready_after_rst", 32'(core_ready), 32'h1);
    router_avail = 1'b1;
    step(); check("t5_idle_a", noc_flit, 32'h0);
    step(); check("t5_idle_b", noc_flit, 32'h0);
    step(); check("t5_idle_c", noc_flit, 32'h0);

    // 6: stats. Pushing 3 with router blocked stalls on the 2nd and 3rd push edges (count 1, 2),
    // then 3 more blocked cycles give 5 stalls in total.
`ifdef NOC_INJ_STATS_EN
    exp_stall = 16'd2;
`else
    exp_stall = 16'd0;
`endif
    router_avail = 1'b0;
    core_flit = f1; step();
    core_flit = f2; step();
    core_flit = f3; step();
    core_flit = '0;
    check("t6_stall_during_push", 32'(stat_stall), 32'(exp_stall));
    step(); step(); step();
`ifdef NOC_INJ_STATS_EN
    exp_stall = 16'd5;
    exp_sent  = 16'd3;
`else
    exp_stall = 16'd0;
    exp_sent  = 16'd0;
`endif
    check("t6_stall5", 32'(stat_stall), 32'(exp_stall));
    check("t6_sent_before", 32'(stat_sent), 32'h0);
    router_avail = 1'b1;
    step(); check("t6_out1", noc_flit, f1);
    step(); check("t6_out2", noc_flit, f2);
    step(); check("t6_out3", noc_flit, f3);
    step();
    check("t6_sent3", 32'(stat_sent), 32'(exp_sent));
    check("t6_stall_final", 32'(stat_stall), 32'(exp_stall));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
